// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved main memory responder for cache refill/writeback traffic.
// Each accepted access holds its bank for BUSY_CYC cycles; reads return after RD_LAT cycles.
module banked_mem_responder #(
    parameter int BANK_AW  = 13,
    parameter int BUSY_CYC = 4,
    parameter int RD_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Wr,
    input  logic        Rd,
    output logic [15:0] DataOut,
    output logic        DataValid,
    output logic        Stall,
    output logic [3:0]  Busy,
    output logic        err
);

    localparam int DEPTH = 1 << BANK_AW;
    localparam int CW    = $clog2(BUSY_CYC);

    // Banks are flattened into one array indexed by {bank, word}; contents survive reset.
    logic [15:0]          mem [0:4*DEPTH-1];
    logic [CW-1:0]        cnt [4];
    logic [RD_LAT-1:0]    pipe_v;
    logic [15:0]          pipe_d [RD_LAT];

    logic [1:0]           bank;
    logic [BANK_AW-1:0]   word;
    logic [BANK_AW+1:0]   idx;
    logic                 req;
    logic                 bad;
    logic                 accept;

    assign bank   = Addr[2:1];
    assign word   = Addr[3 +: BANK_AW];
    assign idx    = {bank, word};
    assign req    = Rd | Wr;
    assign bad    = (Rd & Wr) | (req & Addr[0]);
    assign accept = req & ~bad & ~Busy[bank];
    assign Stall  = req & ~bad & Busy[bank];

    always_comb begin
        Busy = '0;
        for (int i = 0; i < 4; i++) begin
            Busy[i] = (cnt[i] != '0);
        end
    end

    assign DataValid = pipe_v[RD_LAT-1];
    assign DataOut   = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : '0;

    always_ff @(posedge clk) begin
        if (rst && accept && Wr) begin
            mem[idx] <= DataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_d[i] <= '0;
            end
            pipe_v <= '0;
            err    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (bank == 2'(i))) begin
                    cnt[i] <= CW'(BUSY_CYC - 1);
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            // Read data is snapshotted at accept, so later writes cannot disturb it.
            pipe_v[0] <= accept & Rd;
            pipe_d[0] <= (accept && Rd) ? mem[idx] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            if (bad) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_banked_mem_responder.sv
// Scoreboard bench for banked_mem_responder: a cycle-level reference model predicts
// stalls, busy flags, errors and read returns; a monitor pops expected reads.
module tb_banked_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Wr;
    logic        Rd;
    logic [15:0] DataOut;
    logic        DataValid;
    logic        Stall;
    logic [3:0]  Busy;
    logic        err;

    banked_mem_responder dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Wr(Wr), .Rd(Rd),
        .DataOut(DataOut), .DataValid(DataValid), .Stall(Stall), .Busy(Busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          due;
        bit          known;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem_m[int];
    int          free_at[4];
    bit          err_m;
    int          cyc = 0;
    bit          chk_en = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: a read is due this cycle or the output must be idle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_valid", DataValid, 1);
                if (e.known) check("read_data", DataOut, e.data);
            end else begin
                check("valid_idle", DataValid, 0);
                check("dout_idle", DataOut, 0);
            end
        end
    end

    // One cycle of stimulus plus the model's view of that cycle.
    task automatic do_cycle(input bit r_n, input bit rd, input bit wr,
                            input logic [15:0] a, input logic [15:0] d, output bit stalled);
        bit       req, bad, bsy, exp_stall;
        int       b, key;
        logic [3:0] exp_busy;
        @(negedge clk);
        rst = r_n; Rd = rd; Wr = wr; Addr = a; DataIn = d;
        #1;
        b   = int'(a[2:1]);
        key = b * 8192 + int'(a[15:3]);
        req = rd | wr;
        bad = (rd & wr) | (req & a[0]);
        for (int i = 0; i < 4; i++) exp_busy[i] = (cyc < free_at[i]);
        bsy = exp_busy[b];
        exp_stall = req & ~bad & bsy;
        check("stall", Stall, exp_stall);
        check("busy", Busy, exp_busy);
        check("err", err, err_m);
        stalled = exp_stall;
        if (!r_n) begin
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
            for (int i = 0; i < 4; i++) free_at[i] = 0;
            err_m = 0;
        end else if (bad) begin
            err_m = 1;
        end else if (req && !bsy) begin
            free_at[b] = cyc + 4;
            if (wr) begin
                mem_m[key] = d;
            end else begin
                exp_t e;
                e.due   = cyc + 2;
                e.known = mem_m.exists(key);
                e.data  = e.known ? mem_m[key] : 16'h0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) do_cycle(1, 0, 0, 16'h0, 16'h0, s);
    endtask

    task automatic do_reset(input int n);
        bit s;
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 16'h0, 16'h0, s);
    endtask

    // Issue a legal request, holding it while the model predicts a stall.
    task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        bit s;
        int n = 0;
        do begin
            do_cycle(1, rd, wr, a, d, s);
            n++;
        end while (s && n < 8);
        if (s) check("stall_timeout", 1, 0);
    endtask

    initial begin
        bit s;
        logic [15:0] a;
        err_m = 0;
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        rst = 0; Rd = 0; Wr = 0; Addr = 0; DataIn = 0;
        repeat (2) @(posedge clk);
        chk_en = 1;
        do_reset(2);

        // write then stalled read of the same bank
        issue(0, 1, 16'h0010, 16'hBEEF);
        issue(1, 0, 16'h0010, 16'h0);
        idle(4);

        // interleaved block read
        issue(0, 1, 16'h0100, 16'd1);
        issue(0, 1, 16'h0102, 16'd2);
        issue(0, 1, 16'h0104, 16'd3);
        issue(0, 1, 16'h0106, 16'd4);
        idle(4);
        for (int i = 0; i < 4; i++) issue(1, 0, 16'h0100 + 16'(2*i), 16'h0);
        idle(4);

        // writeback pattern and readback
        for (int i = 0; i < 4; i++) issue(0, 1, 16'h0208 + 16'(2*i), 16'hA000 + 16'(i));
        idle(4);
        for (int i = 0; i < 4; i++) issue(1, 0, 16'h0208 + 16'(2*i), 16'h0);
        idle(4);

        // error: simultaneous Rd/Wr does not write
        issue(0, 1, 16'h0000, 16'h1234);
        idle(4);
        do_cycle(1, 1, 1, 16'h0000, 16'hDEAD, s);
        idle(1);
        issue(1, 0, 16'h0000, 16'h0);
        idle(4);

        // error: odd address read after reset
        do_reset(1);
        do_cycle(1, 1, 0, 16'h0001, 16'h0, s);
        idle(4);

        // reset while a read is in flight
        do_reset(1);
        issue(1, 0, 16'h0010, 16'h0);
        do_reset(1);
        idle(3);
        issue(1, 0, 16'h0010, 16'h0);
        idle(4);

        // randomized traffic over a preloaded region
        for (int w = 0; w < 8; w++)
            for (int b = 0; b < 4; b++)
                issue(0, 1, 16'h0300 | 16'(w << 3) | 16'(b << 1), 16'($urandom));
        for (int n = 0; n < 400; n++) begin
            int sel;
            a   = 16'h0300 | 16'($urandom_range(0, 7) << 3) | 16'($urandom_range(0, 3) << 1);
            sel = $urandom_range(0, 99);
            if (sel < 3)       do_reset(1);
            else if (sel < 7)  do_cycle(1, 1, ($urandom_range(0, 1) == 1), a | 16'h1, 16'($urandom), s);
            else if (sel < 30) idle(1);
            else if (sel < 65) issue(1, 0, a, 16'h0);
            else               issue(0, 1, a, 16'($urandom));
        end
        idle(6);
        check("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
